pixel_fb_writer: RTL
====================

PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have parameters: PIXEL_ADDR_WIDTH 16, pixel coordinate width; FB_WIDTH 320, framebuffer columns; FB_HEIGHT 240, framebuffer rows; MEM_ADDR_WIDTH 17, memory word address width; COLOR_WIDTH 8, pixel data width; FIFO_DEPTH 4, input buffer entries (power of 2); CLEAR_COLOR 0, clear fill value.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 x, y  in  PIXEL_ADDR_WIDTH each  pixel coordinates.
REQ-005 color  in  COLOR_WIDTH  pixel value, sampled with x/y.
REQ-006 valid  in  1 / ready  out  1  pixel stream handshake; transfer when both high at a rising edge.
REQ-007 clear  in  1  single-cycle request to fill the whole framebuffer with CLEAR_COLOR.
REQ-008 busy  out  1  high while a clear is pending or running.
REQ-009 mem_we  out  1 / mem_addr  out  MEM_ADDR_WIDTH / mem_wdata  out  COLOR_WIDTH  write request; mem_ack  in  1  memory accepts the write when mem_we and mem_ack are both high at a rising edge.
REQ-010 pix_count  out  32  writes retired since reset; drop_count  out  16  pixels discarded by clipping.

Function
REQ-011 Two states: ST_STREAM (pixel writes) and ST_CLEAR (fill sweep).
REQ-012 ready = ST_STREAM and FIFO not full and no clear pending; combinational from registered state only, never from valid.
REQ-013 Accepted pixels enter a FIFO of FIFO_DEPTH entries holding {x, y, color}; order preserved.
REQ-014 Output stage: one register; loads the FIFO head when empty or retiring this cycle; mem_addr = y*FB_WIDTH + x, truncated to MEM_ADDR_WIDTH; mem_wdata = color.
REQ-015 Latency: with FIFO and output stage empty, a pixel accepted at edge k drives mem_we high after edge k+2; with mem_ack held high, sustained throughput is one write per cycle.
REQ-016 mem_we, mem_addr and mem_wdata SHALL stay stable while mem_we=1 and mem_ack=0.
REQ-017 Simultaneous push and pop on a non-full FIFO SHALL keep the occupancy unchanged.
REQ-018 clear in ST_STREAM sets clear pending and busy on the next edge; ST_CLEAR is entered only when the FIFO and output stage are both empty.
REQ-019 ST_CLEAR writes CLEAR_COLOR to addresses 0 to FB_WIDTH*FB_HEIGHT-1 ascending, advancing one address per acknowledged write; it returns to ST_STREAM and drops busy on the edge that retires the last address.
REQ-020 clear asserted during a pending clear or ST_CLEAR SHALL be ignored (no restart, no queueing).
REQ-021 pix_count increments by 1 per retired write, both pixel and clear writes, and wraps at 2^32.
REQ-022 valid with ready=0 SHALL NOT alter the FIFO; the upstream source holds x/y/color.

Reset
REQ-023 Reset SHALL be sampled at the rising edge of clk only.
REQ-024 While resetn=0: state ST_STREAM, FIFO empty, output stage empty, ready=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_count=0, drop_count=0.
REQ-025 ready SHALL assert on the first cycle after resetn returns high.
REQ-026 Reset during ST_CLEAR or with a full FIFO SHALL abandon all in-flight work, with no further mem_we.

Configuration
REQ-027 Macro PIXEL_FB_CLIP_EN defined: a FIFO head with x>=FB_WIDTH or y>=FB_HEIGHT is popped without a write; drop_count increments by 1 and saturates at 0xFFFF.
REQ-028 Macro undefined: no bounds check; every pixel is written at its truncated address; drop_count is tied to 0.

Structure
REQ-029 Shared package pixel_fb_pkg SHALL hold the state enum, the {x, y, color} pixel record typedef and the FB_PIXELS = FB_WIDTH*FB_HEIGHT constant.
REQ-030 The FIFO SHALL be a separate sub-module pixel_fifo (synchronous, full/empty flags, parameterised width and depth).

Verification
REQ-031 Single pixel (x=5, y=2, color=0xAA), mem_ack=1 -> one write, mem_addr=645, mem_wdata=0xAA, 2 edges after acceptance; pix_count=1.
REQ-032 10 back-to-back pixels, mem_ack=0 for 20 cycles then 1 -> ready low after 5 accepts (FIFO 4 + output 1), mem_addr stable, all 10 written in order, none lost or duplicated.
REQ-033 clear pulse with 3 pixels queued -> 3 pixel writes first, then 76800 writes of 0 to addresses 0 to 76799; busy high throughout; ready=0; pix_count=76803.
REQ-034 PIXEL_FB_CLIP_EN defined, pixels (320,0), (0,240), (319,239) -> single write at addr 76799, drop_count=2; macro undefined -> three writes, at addrs 320, 76800 mod 2^17 = 76800, and 76799.
REQ-035 resetn low for 1 cycle mid-clear at address 1000 -> mem_we=0 next cycle, busy=0, counters 0, ready=1 the cycle after reset releases.
REQ-036 Second clear pulse during ST_CLEAR -> ignored; exactly 76800 clear writes issued.

Source files
------------

// File: rtl/pixel_fb_pkg.sv
`default_nettype none
// ============================================================================
// pixel_fb_pkg : shared types and constants for the framebuffer pixel writer
// Revision: 1.0
// ============================================================================
package pixel_fb_pkg;

  localparam int PIX_COORD_W   = 16;
  localparam int PIX_COLOR_W   = 8;
  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int FB_PIXELS     = FB_WIDTH_DEF * FB_HEIGHT_DEF;

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_CLEAR  = 1'b1
  } fb_state_e;

  typedef struct packed {
    logic [PIX_COORD_W-1:0] x;
    logic [PIX_COORD_W-1:0] y;
    logic [PIX_COLOR_W-1:0] color;
  } pixel_t;

  function automatic int fb_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fb_writer_fifo.sv
`default_nettype none
// ============================================================================
// pixel_fifo : synchronous FIFO, full/empty flags; a new entry becomes
//              poppable one cycle after it is written (DEPTH power of 2, >= 2)
// Revision: 1.0
// ============================================================================
module pixel_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             head_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   wr_vis_q, wr_vis_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  // Read side sees the write pointer one cycle late, adding the pipeline slot
  assign head_valid = (wr_vis_q != rd_ptr_q);
  assign dout       = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_vis_d = wr_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop && head_valid) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_vis_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_vis_q <= wr_vis_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// pixel_fb_writer : buffered pixel stream to framebuffer memory writer with
//                   full-frame clear. Optional macro PIXEL_FB_CLIP_EN enables
//                   bounds clipping and the drop counter.
// Revision: 1.0
// ============================================================================
module pixel_fb_writer
  import pixel_fb_pkg::*;
#(
  parameter int PIXEL_ADDR_WIDTH = 16,
  parameter int FB_WIDTH         = 320,
  parameter int FB_HEIGHT        = 240,
  parameter int MEM_ADDR_WIDTH   = 17,
  parameter int COLOR_WIDTH      = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int CLEAR_COLOR      = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [PIXEL_ADDR_WIDTH-1:0] x,
  input  logic [PIXEL_ADDR_WIDTH-1:0] y,
  input  logic [COLOR_WIDTH-1:0]      color,
  input  logic                        valid,
  output logic                        ready,
  input  logic                        clear,
  output logic                        busy,
  output logic                        mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [COLOR_WIDTH-1:0]      mem_wdata,
  input  logic                        mem_ack,
  output logic [31:0]                 pix_count,
  output logic [15:0]                 drop_count
);

  localparam int FB_AREA = fb_pixels(FB_WIDTH, FB_HEIGHT);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(FB_AREA - 1);

  fb_state_e                  state_q, state_d;
  logic                       clear_pend_q, clear_pend_d;
  logic                       ready_en_q, ready_en_d;
  logic                       out_valid_q, out_valid_d;
  logic [MEM_ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [COLOR_WIDTH-1:0]     out_data_q, out_data_d;
  logic [MEM_ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
  logic [31:0]                pix_count_q, pix_count_d;

  pixel_t                     w_in_pix;
  pixel_t                     w_head;
  logic [$bits(pixel_t)-1:0]  w_head_bits;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_head_valid;
  logic                       w_retire;
  logic                       w_clip;
  logic [MEM_ADDR_WIDTH-1:0]  w_head_addr;

  assign ready  = ready_en_q && (state_q == ST_STREAM) && !w_full && !clear_pend_q;
  assign busy   = clear_pend_q || (state_q == ST_CLEAR);
  assign w_push = valid && ready;

  assign w_in_pix = '{x: PIX_COORD_W'(x), y: PIX_COORD_W'(y), color: PIX_COLOR_W'(color)};
  assign w_head   = w_head_bits;
  // Modular arithmetic in the target width equals truncating the full product
  assign w_head_addr = MEM_ADDR_WIDTH'(w_head.y) * MEM_ADDR_WIDTH'(FB_WIDTH)
                     + MEM_ADDR_WIDTH'(w_head.x);

  pixel_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (w_push),
    .din        (w_in_pix),
    .pop        (w_pop),
    .dout       (w_head_bits),
    .full       (w_full),
    .empty      (w_empty),
    .head_valid (w_head_valid)
  );

  assign mem_we    = (state_q == ST_CLEAR) || out_valid_q;
  assign mem_addr  = (state_q == ST_CLEAR) ? clr_addr_q : out_addr_q;
  assign mem_wdata = (state_q == ST_CLEAR) ? COLOR_WIDTH'(CLEAR_COLOR) : out_data_q;
  assign w_retire  = mem_we && mem_ack;
  assign pix_count = pix_count_q;

  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q;
    ready_en_d   = 1'b1;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    clr_addr_d   = clr_addr_q;
    pix_count_d  = pix_count_q;
    w_pop        = 1'b0;

    if (w_retire) begin
      pix_count_d = pix_count_q + 32'd1;
    end
    if (clear && (state_q == ST_STREAM) && !clear_pend_q) begin
      clear_pend_d = 1'b1;
    end

    case (state_q)
      ST_STREAM: begin
        if (w_retire) begin
          out_valid_d = 1'b0;
        end
        if (w_head_valid && (!out_valid_q || w_retire)) begin
          w_pop = 1'b1;
          if (!w_clip) begin
            out_valid_d = 1'b1;
            out_addr_d  = w_head_addr;
            out_data_d  = COLOR_WIDTH'(w_head.color);
          end
        end
        if (clear_pend_q && w_empty && !out_valid_q) begin
          state_d      = ST_CLEAR;
          clear_pend_d = 1'b0;
          clr_addr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (mem_ack) begin
          if (clr_addr_q == LAST_ADDR) begin
            state_d = ST_STREAM;
          end else begin
            clr_addr_d = clr_addr_q + MEM_ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_STREAM;
      clear_pend_q <= 1'b0;
      ready_en_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      clr_addr_q   <= '0;
      pix_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      ready_en_q   <= ready_en_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      clr_addr_q   <= clr_addr_d;
      pix_count_q  <= pix_count_d;
    end
  end

`ifdef PIXEL_FB_CLIP_EN
  logic [15:0] drop_count_q, drop_count_d;

  assign w_clip     = (32'(w_head.x) >= FB_WIDTH) || (32'(w_head.y) >= FB_HEIGHT);
  assign drop_count = drop_count_q;

  always_comb begin
    drop_count_d = drop_count_q;
    if (w_pop && w_clip && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end
`else
  assign w_clip     = 1'b0;
  assign drop_count = 16'd0;
`endif

endmodule
`default_nettype wire
